note_detector: RTL

Measures the period of an incoming square-wave tone and identifies which of the seven natural notes (do through si) it is. It is the receive end of the note generators, which divide `clock_in` by a fixed divisor. The block counts `clock_in` cycles between rising edges of the tone and compares each period against the nominal divisors. It asserts `note_valid` once the same note has been seen on enough consecutive periods. It sits between an external or looped-back tone line and the display/scoring logic.

---
 rtl/note_pkg.sv | 34 +++
 rtl/note_detector_if.sv | 21 ++
 rtl/tone_edge_sync.sv | 24 ++
 rtl/note_detector.sv | 122 ++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared note constants: note codes, nominal periods (also the generator
// divisors) and the detector FSM state type.
package note_pkg;

  localparam int PERIOD_W = 28;

  typedef logic [PERIOD_W-1:0] period_t;

  typedef enum logic [2:0] {
    NOTE_DO   = 3'd0,
    NOTE_RE   = 3'd1,
    NOTE_MI   = 3'd2,
    NOTE_FA   = 3'd3,
    NOTE_SOL  = 3'd4,
    NOTE_LA   = 3'd5,
    NOTE_SI   = 3'd6,
    NOTE_NONE = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOCKING,
    ST_LOCKED
  } state_e;

  localparam period_t PERIOD_MAX = '1;

  localparam period_t NOTE_PERIOD [0:6] = '{
    28'd381679, 28'd340530, 28'd303370, 28'd286344,
    28'd255102, 28'd227273, 28'd202478
  };

endpackage

// File: rtl/note_detector_if.sv
// Tone line in, measurement and note results out.
interface note_detector_if;
  import note_pkg::*;

  logic       tone_in;
  period_t    period;
  logic       period_strobe;
  logic [2:0] note_code;
  logic       note_valid;

  modport master (
    output tone_in,
    input  period, period_strobe, note_code, note_valid
  );

  modport slave (
    input  tone_in,
    output period, period_strobe, note_code, note_valid
  );

endinterface

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer, one-flop delay and a registered rising-edge pulse.
// The synchronizer chain is not reset so a tone that is high across a reset
// does not fake a rising edge afterwards.
module tone_edge_sync (
  input  logic clock_in,
  input  logic reset,
  input  logic tone_in,
  output logic tone_edge
);

  logic meta_p0;
  logic sync_p1;
  logic dly_p2;

  // sync -> delay -> edge pulse, edge seen three cycles after tone rises
  always_ff @(posedge clock_in) begin
    meta_p0 <= tone_in;
    sync_p1 <= meta_p0;
    dly_p2  <= sync_p1;
    if (reset) tone_edge <= 1'b0;
    else       tone_edge <= sync_p1 & ~dly_p2;
  end

endmodule

// File: rtl/note_detector.sv
// Measures tone period in clock_in cycles, classifies it against the
// nominal note table and locks once a note repeats STABLE_COUNT times.
module note_detector
  import note_pkg::*;
#(
  parameter int      TOL_SHIFT     = 6,
  parameter int      STABLE_COUNT  = 2,
  parameter period_t TIMEOUT       = 28'd800000,
  // nominal table; defaults to the divisors the generators use
  parameter period_t NOMINAL [0:6] = NOTE_PERIOD
) (
  input  logic           clock_in,
  input  logic           reset,
  note_detector_if.slave bus
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_COUNT);

  logic       tone_edge;
  period_t    cnt;
  period_t    cnt_inc;
  logic       report;
  logic       timeout;
  state_e     state, state_n;
  note_e      cand, cand_n;
  note_e      result;
  note_e      code_n;
  logic       valid_n;
  logic [7:0] match_cnt, mc_n, mc_inc;

  // Lowest code wins: scan downward so later (lower) matches overwrite.
  function automatic note_e classify(input period_t p);
    note_e   res;
    period_t diff;
    period_t tol;
    res = NOTE_NONE;
    for (int i = 6; i >= 0; i--) begin
      tol  = NOMINAL[i] >> TOL_SHIFT;
      diff = (p >= NOMINAL[i]) ? p - NOMINAL[i] : NOMINAL[i] - p;
      if (diff <= tol) res = note_e'(i[2:0]);
    end
    return res;
  endfunction

  tone_edge_sync u_sync (
    .clock_in  (clock_in),
    .reset     (reset),
    .tone_in   (bus.tone_in),
    .tone_edge (tone_edge)
  );

  assign cnt_inc = (cnt == PERIOD_MAX) ? PERIOD_MAX : cnt + period_t'(1);
  assign report  = tone_edge && (state != ST_IDLE);
  assign timeout = (state != ST_IDLE) && !tone_edge && (cnt >= TIMEOUT);
  assign result  = classify(bus.period);
  assign mc_inc  = match_cnt + 8'd1;

  // Saturating period counter, cleared on each rising edge
  always_ff @(posedge clock_in) begin
    if (reset)          cnt <= '0;
    else if (tone_edge) cnt <= '0;
    else                cnt <= cnt_inc;
  end

  // Period capture stage: one cycle after the edge, skipped for the first edge
  always_ff @(posedge clock_in) begin
    if (reset) begin
      bus.period        <= '0;
      bus.period_strobe <= 1'b0;
    end else begin
      bus.period_strobe <= report;
      if (report) bus.period <= cnt_inc;
    end
  end

  // Next state: classification acts on the strobe, edges arm, silence times out
  always_comb begin
    state_n = state;
    cand_n  = cand;
    mc_n    = match_cnt;
    if (bus.period_strobe && state != ST_IDLE) begin
      if (result == NOTE_NONE) begin
        mc_n    = '0;
        state_n = ST_ARMED;
      end else if (state == ST_LOCKED && result == cand) begin
        state_n = ST_LOCKED;
      end else if (state == ST_LOCKING && result == cand) begin
        mc_n = mc_inc;
        if (mc_inc >= STABLE_C) state_n = ST_LOCKED;
      end else begin
        cand_n  = result;
        mc_n    = 8'd1;
        state_n = (STABLE_C <= 8'd1) ? ST_LOCKED : ST_LOCKING;
      end
    end else if (tone_edge && state == ST_IDLE) begin
      state_n = ST_ARMED;
    end else if (timeout) begin
      state_n = ST_IDLE;
      mc_n    = '0;
    end
    valid_n = (state_n == ST_LOCKED);
    code_n  = valid_n ? cand_n : NOTE_NONE;
  end

  // Note stage: state, candidate and registered note outputs
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state          <= ST_IDLE;
      cand           <= NOTE_NONE;
      match_cnt      <= '0;
      bus.note_code  <= NOTE_NONE;
      bus.note_valid <= 1'b0;
    end else begin
      state          <= state_n;
      cand           <= cand_n;
      match_cnt      <= mc_n;
      bus.note_code  <= code_n;
      bus.note_valid <= valid_n;
    end
  end

endmodule
